// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants: modulus, gamma2/alpha per security level, sec_lvl encodings.
// Also decodes sec_lvl into the internal decompose mode used by the datapath.
package dilithium_pkg;

    localparam int COEFF_W = 24;

    localparam int Q = 8380417;

    localparam int GAMMA2_L2  = 95232;
    localparam int ALPHA_L2   = 190464;
    localparam int GAMMA2_L35 = 261888;
    localparam int ALPHA_L35  = 523776;

    // (q-1)/alpha: the r1 value that folds back to 0, and the hint modulus m
    localparam int R1_MOD_L2  = 44;
    localparam int R1_MOD_L35 = 16;

    localparam logic [2:0] SEC_LVL2 = 3'b010;
    localparam logic [2:0] SEC_LVL3 = 3'b011;
    localparam logic [2:0] SEC_LVL5 = 3'b101;

    typedef enum logic [1:0] {
        LVL_BYPASS = 2'd0,
        LVL_G88    = 2'd1,
        LVL_G32    = 2'd2
    } lvl_e;

    function automatic lvl_e decode_lvl(input logic [2:0] sec);
        case (sec)
            SEC_LVL2:           decode_lvl = LVL_G88;
            SEC_LVL3, SEC_LVL5: decode_lvl = LVL_G32;
            default:            decode_lvl = LVL_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/decompose_lane.sv
// Per-coefficient Decompose: r -> (r1, r0 as residue mod q), or raw pass-through in bypass mode.
// Latency: 3 cycles (reduce / divide / centre+wrap+hint); all stages advance together on adv.
// Backpressure: when adv is low every register holds, so the output stage stays stable.
module decompose_lane
    import dilithium_pkg::*;
#(
    parameter int COEFF_W = dilithium_pkg::COEFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic [1:0]         lvl,
    input  logic               hint,
    input  logic [COEFF_W-1:0] r,
    output logic [COEFF_W-1:0] r1,
    output logic [COEFF_W-1:0] r0
);

    localparam logic [COEFF_W-1:0] Q_C = COEFF_W'(Q);

    logic [COEFF_W-1:0] red_c;
    logic [COEFF_W-1:0] raw1, raw2;
    logic [23:0]        red1;
    logic [1:0]         lvl1, lvl2;
    logic               hint_d, hint_dd;

    logic [23:0] alpha1, quo_c;
    logic [23:0] quo2, rem2;

    logic [23:0] gamma2_2, alpha2, mod2;
    logic [23:0] r1_c, r0_c, dob_c;
    logic        rnd_up, wrap;

    // Inputs are guaranteed below 2q, so a single conditional subtract reduces fully.
    assign red_c = (r >= Q_C) ? r - Q_C : r;

    always_ff @(posedge clk) begin
        if (adv) begin
            raw1   <= r;
            red1   <= 24'(red_c);
            lvl1   <= lvl;
            hint_d <= hint;
        end
    end

    always_comb begin
        alpha1 = (lvl1 == LVL_G88) ? 24'(ALPHA_L2) : 24'(ALPHA_L35);
        quo_c  = (lvl1 == LVL_G88) ? red1 / 24'(ALPHA_L2) : red1 / 24'(ALPHA_L35);
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            raw2    <= raw1;
            lvl2    <= lvl1;
            hint_dd <= hint_d;
            quo2    <= quo_c;
            rem2    <= red1 - quo_c * alpha1;
        end
    end

    // r0 is carried as 24-bit two's complement; |r0| <= alpha fits comfortably.
    always_comb begin
        gamma2_2 = (lvl2 == LVL_G88) ? 24'(GAMMA2_L2)  : 24'(GAMMA2_L35);
        alpha2   = (lvl2 == LVL_G88) ? 24'(ALPHA_L2)   : 24'(ALPHA_L35);
        mod2     = (lvl2 == LVL_G88) ? 24'(R1_MOD_L2)  : 24'(R1_MOD_L35);
        rnd_up   = (rem2 > gamma2_2);
        r1_c     = quo2 + {23'd0, rnd_up};
        r0_c     = rnd_up ? rem2 - alpha2 : rem2;
        wrap     = (r1_c == mod2);
        if (wrap) begin
            r1_c = '0;
            r0_c = r0_c - 24'd1;
        end
        if (hint_dd) begin
            if (!r0_c[23] && (r0_c != '0))
                r1_c = (r1_c == mod2 - 24'd1) ? '0 : r1_c + 24'd1;
            else
                r1_c = (r1_c == '0) ? mod2 - 24'd1 : r1_c - 24'd1;
        end
        dob_c = r0_c[23] ? r0_c + 24'(Q) : r0_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= '0;
            r0 <= '0;
        end else if (adv) begin
            if (lvl2 == LVL_BYPASS) begin
                r1 <= '0;
                r0 <= raw2;
            end else begin
                r1 <= COEFF_W'(r1_c);
                r0 <= COEFF_W'(dob_c);
            end
        end
    end

endmodule

// File: rtl/decomposer_pipe.sv
// LANES-wide Dilithium Decompose pipeline; optional hint correction under DECOMPOSER_USEHINT_EN.
// Latency: 3 cycles, one beat per cycle; valid_o rises on the third edge counting the transfer edge.
// Backpressure: ready_i drops while stage 3 holds a beat that ready_o refuses; all stages then hold.
module decomposer_pipe
    import dilithium_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COEFF_W = dilithium_pkg::COEFF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               sec_lvl,
    input  logic                     valid_i,
    output logic                     ready_i,
    input  logic [LANES*COEFF_W-1:0] di,
    output logic [LANES*COEFF_W-1:0] doa,
    output logic [LANES*COEFF_W-1:0] dob,
    output logic                     valid_o,
    input  logic                     ready_o
`ifdef DECOMPOSER_USEHINT_EN
    ,
    input  logic                     use_hint_i,
    input  logic [LANES-1:0]         hint_i
`endif
);

    logic             adv;
    logic             v1, v2, v3;
    logic [1:0]       lvl_in;
    logic [LANES-1:0] hint_v;

    assign adv     = !(v3 && !ready_o);
    assign ready_i = adv && !rst;
    assign valid_o = v3;
    assign lvl_in  = decode_lvl(sec_lvl);

`ifdef DECOMPOSER_USEHINT_EN
    assign hint_v = use_hint_i ? hint_i : '0;
`else
    assign hint_v = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= valid_i;
            v2 <= v1;
            v3 <= v2;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        decompose_lane #(
            .COEFF_W (COEFF_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .lvl  (lvl_in),
            .hint (hint_v[k]),
            .r    (di[k*COEFF_W +: COEFF_W]),
            .r1   (doa[k*COEFF_W +: COEFF_W]),
            .r0   (dob[k*COEFF_W +: COEFF_W])
        );
    end

endmodule

// File: tb/tb_decomposer_pipe.sv
// Bench for decomposer_pipe: directed vector table, stall / reset sequences, randomized traffic
// checked against an arithmetic reference model through an ordered scoreboard.
module tb_decomposer_pipe;

    localparam int  LANES = 4;
    localparam int  W     = 24;
    localparam longint QREF = 8380417;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           sec_lvl;
    logic                 valid_i;
    logic                 ready_i;
    logic [LANES*W-1:0]   di;
    logic [LANES*W-1:0]   doa;
    logic [LANES*W-1:0]   dob;
    logic                 valid_o;
    logic                 ready_o;
`ifdef DECOMPOSER_USEHINT_EN
    logic                 use_hint_i;
    logic [LANES-1:0]     hint_i;
`endif

    always #5 clk = ~clk;

    decomposer_pipe #(.LANES(LANES), .COEFF_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_lvl    (sec_lvl),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .di         (di),
        .doa        (doa),
        .dob        (dob),
        .valid_o    (valid_o),
        .ready_o    (ready_o)
`ifdef DECOMPOSER_USEHINT_EN
        ,
        .use_hint_i (use_hint_i),
        .hint_i     (hint_i)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [LANES*W-1:0] act,
                             input logic [LANES*W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model straight from the decomposition rules, in signed integer arithmetic.
    function automatic void ref_lane(input logic [2:0] sec, input longint r_in, input bit hint_on,
                                     output longint r1, output longint r0_out);
        longint g, a, m, r, r0;
        case (sec)
            3'b010:         g = 95232;
            3'b011, 3'b101: g = 261888;
            default: begin
                r1     = 0;
                r0_out = r_in;
                return;
            end
        endcase
        a = 2 * g;
        m = (QREF - 1) / a;
        r = r_in;
        if (r >= QREF) r = r - QREF;
        r0 = r % a;
        if (r0 > g) r0 = r0 - a;
        if (r - r0 == QREF - 1) begin
            r1 = 0;
            r0 = r0 - 1;
        end else begin
            r1 = (r - r0) / a;
        end
        if (hint_on) r1 = (r0 > 0) ? (r1 + 1) % m : (r1 + m - 1) % m;
        r0_out = (r0 < 0) ? r0 + QREF : r0;
    endfunction

    typedef struct {
        logic [LANES*W-1:0] a;
        logic [LANES*W-1:0] b;
    } exp_t;

    function automatic exp_t ref_beat(input logic [2:0] sec, input logic [LANES*W-1:0] d,
                                      input logic [LANES-1:0] h);
        exp_t   e;
        longint r1, r0;
        for (int k = 0; k < LANES; k++) begin
            ref_lane(sec, longint'(d[k*W +: W]), h[k], r1, r0);
            e.a[k*W +: W] = W'(r1);
            e.b[k*W +: W] = W'(r0);
        end
        return e;
    endfunction

    exp_t             sb[$];
    exp_t             mon_e;
    logic [LANES-1:0] mon_h;
    int               out_cnt = 0;

    // Monitor runs mid-cycle: inputs change only just after rising edges.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (valid_i && ready_i) begin
                mon_h = '0;
`ifdef DECOMPOSER_USEHINT_EN
                if (use_hint_i) mon_h = hint_i;
`endif
                sb.push_back(ref_beat(sec_lvl, di, mon_h));
            end
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1'b0, 1, 0);
                end else begin
                    mon_e = sb[0];
                    check_vec("beat_doa", doa, mon_e.a);
                    check_vec("beat_dob", dob, mon_e.b);
                    if (ready_o) begin
                        void'(sb.pop_front());
                        out_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input logic [2:0] s, input logic [LANES*W-1:0] d);
        bit acc;
        acc     = 1'b0;
        sec_lvl = s;
        di      = d;
        valid_i = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = ready_i;
            tick();
        end
        if (!acc) check("accept_timeout", 1'b0, 0, 1);
    endtask

    function automatic logic [W-1:0] rand_coeff();
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0:       return W'(QREF - 1 - $urandom_range(0, 3));
            1:       return W'(QREF + $urandom_range(0, 1000));
            2:       return W'(95231 + $urandom_range(0, 2));
            3:       return W'(261887 + $urandom_range(0, 2));
            default: return W'($urandom_range(0, 8380416));
        endcase
    endfunction

    function automatic logic [LANES*W-1:0] rand_vec();
        logic [LANES*W-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*W +: W] = rand_coeff();
        return v;
    endfunction

    function automatic logic [2:0] rand_sec();
        case ($urandom_range(0, 4))
            0:       return 3'b010;
            1:       return 3'b011;
            2:       return 3'b101;
            3:       return 3'($urandom_range(0, 7));
            default: return 3'b010;
        endcase
    endfunction

    task automatic drain(input string name);
        valid_i = 1'b0;
        ready_o = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check(name, sb.size() == 0, sb.size(), 0);
    endtask

    typedef struct {
        logic [2:0] sec;
        int         r;
        int         ea;
        int         eb;
    } vec_t;

    vec_t               tbl[13];
    logic [LANES*W-1:0] dv;
    int                 cnt0;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'b010, 0,       0, 0};
        tbl[1]  = '{3'b010, 8380416, 0, 8380416};
        tbl[2]  = '{3'b010, 95232,   0, 95232};
        tbl[3]  = '{3'b010, 95233,   1, 8285186};
        tbl[4]  = '{3'b011, 1000000, 2, 8332865};
        tbl[5]  = '{3'b101, 1000000, 2, 8332865};
        tbl[6]  = '{3'b011, 8380416, 0, 8380416};
        tbl[7]  = '{3'b010, 190464,  1, 0};
        tbl[8]  = '{3'b010, 8289952, 0, 8289952};
        tbl[9]  = '{3'b010, 8380417, 0, 0};
        tbl[10] = '{3'b000, 12345,   0, 12345};
        tbl[11] = '{3'b111, 8380422, 0, 8380422};
        tbl[12] = '{3'b101, 261889,  1, 8118530};

        rst     = 1'b1;
        valid_i = 1'b0;
        ready_o = 1'b1;
        sec_lvl = 3'b000;
        di      = '0;
`ifdef DECOMPOSER_USEHINT_EN
        use_hint_i = 1'b0;
        hint_i     = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o == 1'b0, valid_o, 0);
        check("rst_ready_i", ready_i == 1'b0, ready_i, 0);
        check("rst_doa", doa == '0, longint'(doa[W-1:0]), 0);
        check("rst_dob", dob == '0, longint'(dob[W-1:0]), 0);
        #1;
        rst = 1'b0;
        tick();

        // Directed single beats: valid_o must be low one edge after transfer, high on the next.
        for (int i = 0; i < 13; i++) begin
            dv = rand_vec();
            dv[W-1:0] = W'(tbl[i].r);
            send_beat(tbl[i].sec, dv);
            valid_i = 1'b0;
            @(posedge clk);
            #1;
            check("lat_early", valid_o == 1'b0, valid_o, 0);
            @(posedge clk);
            #1;
            check("lat_3", valid_o == 1'b1, valid_o, 1);
            check("vec_doa", doa[W-1:0] == W'(tbl[i].ea), longint'(doa[W-1:0]), tbl[i].ea);
            check("vec_dob", dob[W-1:0] == W'(tbl[i].eb), longint'(dob[W-1:0]), tbl[i].eb);
            #1;
        end
        drain("drain_directed");

`ifdef DECOMPOSER_USEHINT_EN
        use_hint_i = 1'b1;
        hint_i     = '1;
        dv = rand_vec();
        dv[W-1:0] = W'(8380416);
        send_beat(3'b011, dv);
        valid_i = 1'b0;
        use_hint_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hint_doa", doa[W-1:0] == W'(15), longint'(doa[W-1:0]), 15);
        #1;
        drain("drain_hint");
`endif

        // Eight beats with a five-cycle downstream stall mid-stream.
        cnt0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(rand_sec(), rand_vec());
                valid_i = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2 ready_o = 1'b0;
                repeat (5) @(posedge clk);
                #2 ready_o = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_count", out_cnt - cnt0 == 8, out_cnt - cnt0, 8);

        // Reset with two beats in flight.
        send_beat(3'b010, rand_vec());
        send_beat(3'b011, rand_vec());
        valid_i = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_mid_ready", ready_i == 1'b0, ready_i, 0);
        @(posedge clk);
        #1;
        check("rst_mid_valid", valid_o == 1'b0, valid_o, 0);
        #1;
        rst  = 1'b0;
        cnt0 = out_cnt;
        repeat (8) tick();
        check("rst_no_stale", out_cnt == cnt0, out_cnt - cnt0, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            ready_o = ($urandom_range(0, 9) < 7);
            sec_lvl = rand_sec();
            di      = rand_vec();
`ifdef DECOMPOSER_USEHINT_EN
            use_hint_i = $urandom_range(0, 1) == 1;
            hint_i     = LANES'($urandom_range(0, (1 << LANES) - 1));
`endif
            tick();
        end
        drain("drain_random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decomposer_pipe.md
DECOMPOSER_PIPE -- requirements
Module: decomposer_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, coefficients per beat (legal values 1, 2, 4, 8).
REQ-002 SHALL have parameter COEFF_W, default 24, bits per coefficient.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port sec_lvl, input, 3, security level, sampled with each accepted beat.
REQ-006 SHALL have port valid_i, input, 1, upstream beat valid.
REQ-007 SHALL have port ready_i, output, 1, block can accept a beat.
REQ-008 SHALL have port di, input, LANES*COEFF_W, coefficients r; lane k in bits [k*COEFF_W +: COEFF_W].
REQ-009 SHALL have port doa, output, LANES*COEFF_W, high part r1 per lane, zero-extended.
REQ-010 SHALL have port dob, output, LANES*COEFF_W, low part r0 per lane, as residue in [0,q).
REQ-011 SHALL have port valid_o, output, 1, output beat valid.
REQ-012 SHALL have port ready_o, input, 1, downstream accepts the output beat.

Function
REQ-013 SHALL transfer a beat in when valid_i and ready_i are both 1 at a rising edge, and a beat out when valid_o and ready_o are both 1.
REQ-014 SHALL have fixed latency of 3 cycles from input transfer to valid_o, with 3 pipeline stages each holding a valid bit.
REQ-015 SHALL drive ready_i = NOT(stage-3 valid AND NOT ready_o); while stalled, all stages SHALL hold.
REQ-016 SHALL sustain one beat per cycle when ready_o stays 1; doa, dob and valid_o SHALL stay stable while valid_o=1 and ready_o=0.
REQ-017 SHALL use q = 8380417 throughout.
REQ-018 SHALL decode sec_lvl 3'b010 as gamma2 = 95232 and alpha = 190464 (r1 in 0..43).
REQ-019 SHALL decode sec_lvl 3'b011 and 3'b101 as gamma2 = 261888 and alpha = 523776 (r1 in 0..15).
REQ-020 SHALL treat any other sec_lvl code as bypass: doa = 0 and dob = di, with the same latency.
REQ-021 SHALL first reduce a lane r >= q by one subtraction of q; inputs >= 2q are outside contract.
REQ-022 SHALL compute r0' = r mod alpha, and r0 = r0' - alpha if r0' > gamma2, else r0 = r0'.
REQ-023 SHALL set r1 = 0 and r0 = r0 - 1 when r - r0 = q-1 (wrap case); otherwise r1 = (r - r0)/alpha.
REQ-024 SHALL output a negative r0 as q + r0 on dob.
REQ-025 SHALL apply sec_lvl per beat; consecutive beats with differing sec_lvl SHALL each use their own level.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, clear all stage valid bits and set doa = 0, dob = 0 and valid_o = 0.
REQ-027 SHALL hold ready_i at 0 while rst=1.
REQ-028 SHALL discard in-flight beats on reset mid-operation; none are emitted afterwards.

Configuration
REQ-029 SHALL, with DECOMPOSER_USEHINT_EN defined, add input use_hint_i (1 bit) and input hint_i (LANES bits), both sampled with di.
REQ-030 SHALL, when use_hint_i=1 and hint bit k=1, replace lane-k r1 by (r1+1) mod m if r0 > 0, else (r1-1) mod m; m = 44 (level 2) or 16 (levels 3/5); dob is unchanged.
REQ-031 SHALL, without DECOMPOSER_USEHINT_EN, omit use_hint_i and hint_i and behave as use_hint_i=0.

Structure
REQ-032 SHALL take Q, the GAMMA2/ALPHA constants, the SEC_LVL encodings and COEFF_W from shared package dilithium_pkg.
REQ-033 SHALL implement the per-coefficient 3-stage datapath as sub-module decompose_lane, instantiated LANES times; control and handshake logic stay in decomposer_pipe.

Verification
REQ-034 SHALL cover: sec_lvl=010, lane r=0 -> doa=0, dob=0, valid_o 3 cycles after transfer.
REQ-035 SHALL cover: sec_lvl=010, r=8380416 -> doa=0, dob=8380416 (wrap case).
REQ-036 SHALL cover: sec_lvl=010, r=95232 -> doa=0, dob=95232; r=95233 -> doa=1, dob=8285186.
REQ-037 SHALL cover: sec_lvl=011, r=1000000 -> doa=2, dob=8332865; with USEHINT_EN, use_hint_i=1, h=1, r=8380416 -> doa=15.
REQ-038 SHALL cover: stream of 8 beats with ready_o low for 5 cycles mid-stream -> outputs held stable, no loss or duplication, order preserved.
REQ-039 SHALL cover: rst pulsed with 2 beats in flight -> valid_o=0 next cycle, no stale beat emitted afterwards.
